adc_sample_ctrl: RTL and testbench

ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

---
 rtl/adc_pkg.sv | 15 +
 rtl/wave_ram.sv | 33 +++
 rtl/adc_sample_ctrl.sv | 142 ++++++++++++++
 tb/tb_adc_sample_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the serial ADC sampling controller.
package adc_pkg;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_W     = 12;
    localparam int ADC_LEAD_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } adc_state_t;

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port waveform buffer: synchronous write, registered read-first output.
module wave_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate read process keeps the array free of reset so it maps to block RAM,
    // and a same-address collision returns the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Serial ADC conversion sequencer: generates CS/SCLK, captures a 16-bit frame,
// keeps the last 12 bits as the sample and logs it into the waveform buffer.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int SCLK_DIV = 4,
    parameter int ADDR_W   = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    input  logic                  adc_sdata,
    output logic [ADC_DATA_W-1:0] sample_data,
    output logic                  sample_valid,
    output logic [ADDR_W-1:0]     wr_addr,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [ADC_DATA_W-1:0] rd_data,
    output logic                  overrun,
    output logic                  busy
);

    localparam int              SHIFT_W   = ADC_FRAME_BITS - ADC_LEAD_BITS;
    localparam int              HALF_W    = $clog2(2 * ADC_FRAME_BITS);
    localparam logic [7:0]      CNT_LAST  = 8'(SCLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * ADC_FRAME_BITS - 1);

    adc_state_t         state, state_next;
    logic [7:0]         cnt;
    logic [HALF_W-1:0]  half_cnt;
    logic [1:0]         sync;
    logic [SHIFT_W-1:0] shift_reg;
    logic               cnt_last;
    logic               half_last;
    logic               ram_we;

    assign cnt_last  = (cnt == CNT_LAST);
    assign half_last = (half_cnt == HALF_LAST);
    assign busy      = (state != IDLE);
    assign ram_we    = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = SETUP;
            SETUP:   if (cnt_last) state_next = SHIFT;
            SHIFT:   if (cnt_last && half_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], adc_sdata};
        end
    end

    // A shift register only as wide as the sample drops the leading frame bits
    // naturally once all 16 bits have been shifted through it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            cnt          <= '0;
            half_cnt     <= '0;
            shift_reg    <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            wr_addr      <= '0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= sample_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    half_cnt <= '0;
                    if (sample_tick) begin
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_last) begin
                        cnt      <= '0;
                        adc_sclk <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_last) begin
                        cnt      <= '0;
                        half_cnt <= half_cnt + 1'b1;
                        if (!adc_sclk) begin
                            adc_sclk  <= 1'b1;
                            shift_reg <= {shift_reg[SHIFT_W-2:0], sync[1]};
                        end else if (half_last) begin
                            adc_cs_n     <= 1'b1;
                            sample_data  <= shift_reg;
                            sample_valid <= 1'b1;
                        end else begin
                            adc_sclk <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    wr_addr <= wr_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    wave_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ADC_DATA_W)
    ) u_wave_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .wr_addr (wr_addr),
        .wr_data (sample_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with a behavioural serial ADC that
// updates its data line on every falling SCLK edge.
module tb_adc_sample_ctrl;

    localparam int SCLK_DIV = 4;
    localparam int ADDR_W   = 9;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic              sample_tick = 1'b0;
    logic              adc_sdata   = 1'b0;
    logic [ADDR_W-1:0] rd_addr     = '0;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic [11:0]       sample_data;
    logic              sample_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       rd_data;
    logic              overrun;
    logic              busy;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cs_low_cnt   = 0;
    int          rise_cnt     = 0;
    int          valid_cnt    = 0;
    int          ovr_cnt      = 0;
    logic [11:0] valid_data   = '0;
    logic        prev_sclk    = 1'b1;
    logic [15:0] adc_frame    = '0;
    int          bit_idx      = 16;
    logic [11:0] rd_val;

    adc_sample_ctrl #(
        .SCLK_DIV (SCLK_DIV),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_sdata    (adc_sdata),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ADC model: frame restarts whenever CS is released, next bit presented on each SCLK fall.
    always @(negedge adc_sclk or posedge adc_cs_n) begin
        if (adc_cs_n) begin
            bit_idx = 16;
        end else if (bit_idx > 0) begin
            bit_idx = bit_idx - 1;
            adc_sdata <= adc_frame[bit_idx];
        end
    end

    task clear_counts();
        cs_low_cnt = 0;
        rise_cnt   = 0;
        valid_cnt  = 0;
        ovr_cnt    = 0;
        valid_data = '0;
    endtask

    // One clock cycle: observe outputs at the falling edge, then set the tick for the next rise.
    task step(input logic tick);
        @(negedge clk);
        if (!adc_cs_n) cs_low_cnt++;
        if (!prev_sclk && adc_sclk && !adc_cs_n) rise_cnt++;
        prev_sclk = adc_sclk;
        if (sample_valid) begin
            valid_cnt++;
            valid_data = sample_data;
        end
        if (overrun) ovr_cnt++;
        sample_tick = tick;
    endtask

    task read_buf(input logic [ADDR_W-1:0] addr, output logic [11:0] data);
        @(negedge clk);
        rd_addr = addr;
        @(negedge clk);
        data = rd_data;
    endtask

    task test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({adc_cs_n, adc_sclk, sample_valid, overrun, busy} !== 5'b11000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got cs/sclk/valid/ovr/busy=%b expected 11000",
                     {adc_cs_n, adc_sclk, sample_valid, overrun, busy});
        end
        tests_run++;
        if (sample_data !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_sample_data: got %h expected 000", sample_data);
        end
        tests_run++;
        if (wr_addr !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr);
        end
        tests_run++;
        if (rd_data !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_rd_data: got %h expected 000", rd_data);
        end
        rst_n = 1'b1;
    endtask

    task test_single();
        clear_counts();
        adc_frame = 16'h0ABC;
        step(1'b1);
        repeat (140) step(1'b0);
        tests_run++;
        if (cs_low_cnt !== 132) begin
            tests_failed++;
            $display("[TB] FAIL single_cs_low: got %0d cycles expected 132", cs_low_cnt);
        end
        tests_run++;
        if (rise_cnt !== 16) begin
            tests_failed++;
            $display("[TB] FAIL single_sclk_rises: got %0d expected 16", rise_cnt);
        end
        tests_run++;
        if (valid_cnt !== 1 || valid_data !== 12'hABC) begin
            tests_failed++;
            $display("[TB] FAIL single_valid: got %0d pulses data %h expected 1 pulse data abc",
                     valid_cnt, valid_data);
        end
        tests_run++;
        if (sample_data !== 12'hABC || wr_addr !== 9'd1 || busy !== 1'b0 || ovr_cnt !== 0) begin
            tests_failed++;
            $display("[TB] FAIL single_final: got data %h wr_addr %0d busy %b ovr %0d expected abc 1 0 0",
                     sample_data, wr_addr, busy, ovr_cnt);
        end
        read_buf(9'd0, rd_val);
        tests_run++;
        if (rd_val !== 12'hABC) begin
            tests_failed++;
            $display("[TB] FAIL single_buffer0: got %h expected abc", rd_val);
        end
    endtask

    task test_overrun();
        clear_counts();
        adc_frame = 16'hF123;
        step(1'b1);
        repeat (49) step(1'b0);
        step(1'b1);
        repeat (100) step(1'b0);
        tests_run++;
        if (ovr_cnt !== 1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_pulses: got %0d expected 1", ovr_cnt);
        end
        tests_run++;
        if (valid_cnt !== 1 || cs_low_cnt !== 132 || valid_data !== 12'h123) begin
            tests_failed++;
            $display("[TB] FAIL overrun_conv: got %0d valid, %0d cs-low, data %h expected 1 132 123",
                     valid_cnt, cs_low_cnt, valid_data);
        end
        tests_run++;
        if (wr_addr !== 9'd2) begin
            tests_failed++;
            $display("[TB] FAIL overrun_wr_addr: got %0d expected 2", wr_addr);
        end
        read_buf(9'd1, rd_val);
        tests_run++;
        if (rd_val !== 12'h123) begin
            tests_failed++;
            $display("[TB] FAIL overrun_buffer1: got %h expected 123", rd_val);
        end
    endtask

    task test_done_tick();
        clear_counts();
        adc_frame = 16'h0555;
        step(1'b1);
        repeat (132) step(1'b0);
        step(1'b1);
        repeat (10) step(1'b0);
        tests_run++;
        if (ovr_cnt !== 1 || valid_cnt !== 1 || cs_low_cnt !== 132) begin
            tests_failed++;
            $display("[TB] FAIL done_tick: got ovr %0d valid %0d cs-low %0d expected 1 1 132",
                     ovr_cnt, valid_cnt, cs_low_cnt);
        end
        tests_run++;
        if (wr_addr !== 9'd3 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_tick_state: got wr_addr %0d busy %b expected 3 0", wr_addr, busy);
        end
        clear_counts();
        adc_frame = 16'h0AAA;
        step(1'b1);
        repeat (140) step(1'b0);
        tests_run++;
        if (valid_cnt !== 1 || valid_data !== 12'hAAA || ovr_cnt !== 0 || wr_addr !== 9'd4) begin
            tests_failed++;
            $display("[TB] FAIL done_tick_next: got valid %0d data %h ovr %0d wr_addr %0d expected 1 aaa 0 4",
                     valid_cnt, valid_data, ovr_cnt, wr_addr);
        end
    endtask

    task test_wrap();
        logic [11:0] exp_val;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (wr_addr !== '0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_start_addr: got %0d expected 0", wr_addr);
        end
        clear_counts();
        for (int i = 0; i < 512; i++) begin
            adc_frame = {4'h0, 12'(i * 3 + 1)};
            step(1'b1);
            if (i == 511) begin
                tests_run++;
                if (wr_addr !== 9'd511) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_addr_511: got %0d expected 511", wr_addr);
                end
            end
            repeat (133) step(1'b0);
        end
        repeat (3) step(1'b0);
        tests_run++;
        if (valid_cnt !== 512 || wr_addr !== '0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_end: got valid %0d wr_addr %0d expected 512 0", valid_cnt, wr_addr);
        end
        for (int a = 0; a <= 512; a++) begin
            @(negedge clk);
            if (a > 0) begin
                exp_val = 12'((a - 1) * 3 + 1);
                tests_run++;
                if (rd_data !== exp_val) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_read[%0d]: got %h expected %h", a - 1, rd_data, exp_val);
                end
            end
            if (a < 512) rd_addr = 9'(a);
        end
    endtask

    task test_reset_mid();
        clear_counts();
        adc_frame = 16'h0FFF;
        step(1'b1);
        repeat (60) step(1'b0);
        tests_run++;
        if (busy !== 1'b1 || adc_cs_n !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_precond: got busy %b cs_n %b expected 1 0", busy, adc_cs_n);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({adc_cs_n, adc_sclk, busy, sample_valid} !== 4'b1100) begin
            tests_failed++;
            $display("[TB] FAIL abort_async: got cs/sclk/busy/valid=%b expected 1100",
                     {adc_cs_n, adc_sclk, busy, sample_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        repeat (150) step(1'b0);
        tests_run++;
        if (valid_cnt !== 0 || cs_low_cnt !== 0 || wr_addr !== '0 || sample_data !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL abort_after: got valid %0d cs-low %0d wr_addr %0d data %h expected 0 0 0 000",
                     valid_cnt, cs_low_cnt, wr_addr, sample_data);
        end
        read_buf(9'd0, rd_val);
        tests_run++;
        if (rd_val !== 12'h001) begin
            tests_failed++;
            $display("[TB] FAIL abort_buffer0: got %h expected 001", rd_val);
        end
        read_buf(9'd1, rd_val);
        tests_run++;
        if (rd_val !== 12'h004) begin
            tests_failed++;
            $display("[TB] FAIL abort_buffer1: got %h expected 004", rd_val);
        end
    endtask

    task test_same_addr();
        clear_counts();
        adc_frame = 16'h0777;
        @(negedge clk);
        rd_addr = 9'd0;
        step(1'b1);
        repeat (133) step(1'b0);
        @(negedge clk);
        tests_run++;
        if (rd_data !== 12'h001 || wr_addr !== 9'd1) begin
            tests_failed++;
            $display("[TB] FAIL collide_old: got rd_data %h wr_addr %0d expected 001 1", rd_data, wr_addr);
        end
        @(negedge clk);
        tests_run++;
        if (rd_data !== 12'h777) begin
            tests_failed++;
            $display("[TB] FAIL collide_new: got %h expected 777", rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_done_tick();
        test_wrap();
        test_reset_mid();
        test_same_addr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
